// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage: ALUOp codes, MIPS opcode/funct
// constants, the ID/EX register layout and small immediate helpers.
package alu_issue_stage_pkg;

    // ALU operation codes understood by the EX-stage ALU.
    typedef enum logic [3:0] {
        ALU_NOP   = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_AND   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_SLLV  = 4'd11,
        ALU_SRLV  = 4'd12,
        ALU_SLL16 = 4'd13
    } aluop_e;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic        valid;
        aluop_e      aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rtData;
        logic [4:0]  wreg;
        logic        regwrite;
        logic        memRd;
        logic        memWr;
        logic        illegal;
    } idex_t;

    // A squashed slot: nothing live, nothing written, operands zeroed.
    function automatic idex_t bubble();
        idex_t b;
        b          = '0;
        b.aluop    = ALU_NOP;
        return b;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_alu_decode.sv
// Combinational decoder: instruction word plus register operands in,
// ALUOp, ALU operands and writeback/memory controls out.
module alu_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic [3:0]  aluop_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [4:0]  wreg_o,
    output logic        regwrite_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        illegal_o
);

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instr_i[31:26];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign shamt = instr_i[10:6];
    assign funct = instr_i[5:0];
    assign imm   = instr_i[15:0];

    // Decode op/funct; unknown encodings fall through to an illegal NOP,
    // and writes to $zero are suppressed last so they override everything.
    always_comb begin
        aluop_e aluop;
        logic   ill;
        aluop      = ALU_NOP;
        ill        = 1'b0;
        a_o        = rs_data_i;
        b_o        = rt_data_i;
        wreg_o     = rt;
        regwrite_o = 1'b1;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        case (op)
            OP_RTYPE: begin
                wreg_o = rd;
                case (funct)
                    FN_ADD, FN_ADDU: aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: aluop = ALU_SUB;
                    FN_AND:          aluop = ALU_AND;
                    FN_OR:           aluop = ALU_OR;
                    FN_NOR:          aluop = ALU_NOR;
                    FN_SLT:          aluop = ALU_SLT;
                    FN_SLTU:         aluop = ALU_SLTU;
                    FN_SLL: begin
                        aluop = ALU_SLL;
                        a_o   = {27'b0, shamt};
                    end
                    FN_SRL: begin
                        aluop = ALU_SRL;
                        a_o   = {27'b0, shamt};
                    end
                    FN_SRA: begin
                        aluop = ALU_SRA;
                        a_o   = {27'b0, shamt};
                    end
                    FN_SLLV: begin
                        aluop = ALU_SLLV;
                        a_o   = {27'b0, rs_data_i[4:0]};
                    end
                    FN_SRLV: begin
                        aluop = ALU_SRLV;
                        a_o   = {27'b0, rs_data_i[4:0]};
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                aluop = ALU_ADD;
                b_o   = sext16(imm);
            end
            OP_SLTI: begin
                aluop = ALU_SLT;
                b_o   = sext16(imm);
            end
            OP_SLTIU: begin
                aluop = ALU_SLTU;
                b_o   = sext16(imm);
            end
            OP_ANDI: begin
                aluop = ALU_AND;
                b_o   = zext16(imm);
            end
            OP_ORI: begin
                aluop = ALU_OR;
                b_o   = zext16(imm);
            end
            OP_LUI: begin
                aluop = ALU_SLL16;
                b_o   = zext16(imm);
            end
            OP_LW: begin
                aluop    = ALU_ADD;
                b_o      = sext16(imm);
                mem_rd_o = 1'b1;
            end
            OP_SW: begin
                aluop      = ALU_ADD;
                b_o        = sext16(imm);
                mem_wr_o   = 1'b1;
                regwrite_o = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                aluop      = ALU_SUB;
                regwrite_o = 1'b0;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            aluop      = ALU_NOP;
            regwrite_o = 1'b0;
            mem_rd_o   = 1'b0;
            mem_wr_o   = 1'b0;
        end
        if (wreg_o == 5'd0) begin
            regwrite_o = 1'b0;
        end
        aluop_o   = aluop;
        illegal_o = ill;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ID instruction, captures it into the
// ID/EX pipeline register under stall/flush control and counts issues.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_aluop,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_rt_data,
    output logic [4:0]  ex_wreg,
    output logic        ex_regwrite,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_illegal,
    output logic [31:0] issue_count
);

    logic [3:0]  decAluop;
    logic [31:0] decA;
    logic [31:0] decB;
    logic [4:0]  decWreg;
    logic        decRegwrite;
    logic        decMemRd;
    logic        decMemWr;
    logic        decIllegal;

    idex_t       ex_d;
    idex_t       ex_q;
    logic [31:0] count_d;
    logic [31:0] count_q;

    alu_decode u_decode (
        .instr_i    (id_instr),
        .rs_data_i  (id_rs_data),
        .rt_data_i  (id_rt_data),
        .aluop_o    (decAluop),
        .a_o        (decA),
        .b_o        (decB),
        .wreg_o     (decWreg),
        .regwrite_o (decRegwrite),
        .mem_rd_o   (decMemRd),
        .mem_wr_o   (decMemWr),
        .illegal_o  (decIllegal)
    );

    assign id_ready = ~stall;

    // Next ID/EX contents: flush beats stall, stall holds, otherwise load
    // the decode (or a bubble when ID has nothing valid).
    always_comb begin
        ex_d    = ex_q;
        count_d = count_q;
        if (flush) begin
            ex_d = bubble();
        end else if (!stall) begin
            if (id_valid) begin
                ex_d.valid    = 1'b1;
                ex_d.aluop    = aluop_e'(decAluop);
                ex_d.a        = decA;
                ex_d.b        = decB;
                ex_d.rtData   = id_rt_data;
                ex_d.wreg     = decWreg;
                ex_d.regwrite = decRegwrite;
                ex_d.memRd    = decMemRd;
                ex_d.memWr    = decMemWr;
                ex_d.illegal  = decIllegal;
                count_d       = count_q + 32'd1;
            end else begin
                ex_d = bubble();
            end
        end
    end

    // Pipeline register and issue counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= bubble();
            count_q <= '0;
        end else begin
            ex_q    <= ex_d;
            count_q <= count_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_aluop    = ex_q.aluop;
    assign ex_a        = ex_q.a;
    assign ex_b        = ex_q.b;
    assign ex_rt_data  = ex_q.rtData;
    assign ex_wreg     = ex_q.wreg;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_mem_rd   = ex_q.memRd;
    assign ex_mem_wr   = ex_q.memWr;
    assign ex_illegal  = ex_q.illegal;
    assign issue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expected values.
module tb_alu_issue_stage;

    localparam logic [31:0] NOP_C   = 32'd0;
    localparam logic [31:0] ADD_C   = 32'd1;
    localparam logic [31:0] SUB_C   = 32'd2;
    localparam logic [31:0] OR_C    = 32'd4;
    localparam logic [31:0] SLL_C   = 32'd8;
    localparam logic [31:0] SLL16_C = 32'd13;

    logic        clk;
    logic        rst;
    logic        idValid;
    logic [31:0] idInstr;
    logic [31:0] idRsData;
    logic [31:0] idRtData;
    logic        stall;
    logic        flush;
    logic        idReady;
    logic        exValid;
    logic [3:0]  exAluop;
    logic [31:0] exA;
    logic [31:0] exB;
    logic [31:0] exRtData;
    logic [4:0]  exWreg;
    logic        exRegwrite;
    logic        exMemRd;
    logic        exMemWr;
    logic        exIllegal;
    logic [31:0] issueCount;

    int totalChecks;
    int badChecks;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (idValid),
        .id_instr    (idInstr),
        .id_rs_data  (idRsData),
        .id_rt_data  (idRtData),
        .stall       (stall),
        .flush       (flush),
        .id_ready    (idReady),
        .ex_valid    (exValid),
        .ex_aluop    (exAluop),
        .ex_a        (exA),
        .ex_b        (exB),
        .ex_rt_data  (exRtData),
        .ex_wreg     (exWreg),
        .ex_regwrite (exRegwrite),
        .ex_mem_rd   (exMemRd),
        .ex_mem_wr   (exMemWr),
        .ex_illegal  (exIllegal),
        .issue_count (issueCount)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of ID-side inputs, clocks once, settles past the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] rsD, input logic [31:0] rtD,
                                 input logic st, input logic fl);
        idValid  = v;
        idInstr  = instr;
        idRsData = rsD;
        idRtData = rtD;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering reset, decode classes, stall/flush and reset.
    initial begin
        totalChecks = 0;
        badChecks   = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst_valid", {31'b0, exValid}, 32'd0);
        checkOutput("rst_aluop", {28'b0, exAluop}, NOP_C);
        checkOutput("rst_count", issueCount, 32'd0);
        checkOutput("rst_ready", {31'b0, idReady}, 32'd1);
        rst = 1'b0;

        // addiu $t1,$t0,-4
        applyStimulus(1'b1, 32'h2509FFFC, 32'd10, 32'd77, 1'b0, 1'b0);
        checkOutput("addiu_valid", {31'b0, exValid}, 32'd1);
        checkOutput("addiu_aluop", {28'b0, exAluop}, ADD_C);
        checkOutput("addiu_a", exA, 32'd10);
        checkOutput("addiu_b", exB, 32'hFFFFFFFC);
        checkOutput("addiu_wreg", {27'b0, exWreg}, 32'd9);
        checkOutput("addiu_regwrite", {31'b0, exRegwrite}, 32'd1);
        checkOutput("addiu_count", issueCount, 32'd1);

        // sll $t2,$t1,3
        applyStimulus(1'b1, 32'h000950C0, 32'h12345678, 32'd5, 1'b0, 1'b0);
        checkOutput("sll_aluop", {28'b0, exAluop}, SLL_C);
        checkOutput("sll_a", exA, 32'd3);
        checkOutput("sll_b", exB, 32'd5);
        checkOutput("sll_wreg", {27'b0, exWreg}, 32'd10);
        checkOutput("sll_count", issueCount, 32'd2);

        // lui $t0,0x1234
        applyStimulus(1'b1, 32'h3C081234, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("lui_aluop", {28'b0, exAluop}, SLL16_C);
        checkOutput("lui_b", exB, 32'h00001234);
        checkOutput("lui_wreg", {27'b0, exWreg}, 32'd8);

        // ori $t0,$t0,0x8000
        applyStimulus(1'b1, 32'h35088000, 32'h12340000, 32'd0, 1'b0, 1'b0);
        checkOutput("ori_aluop", {28'b0, exAluop}, OR_C);
        checkOutput("ori_a", exA, 32'h12340000);
        checkOutput("ori_b", exB, 32'h00008000);
        checkOutput("ori_count", issueCount, 32'd4);

        // Stall three cycles while a different instruction waits in ID.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h2509FFFC, 32'd99, 32'd1, 1'b1, 1'b0);
            checkOutput("stall_ready", {31'b0, idReady}, 32'd0);
            checkOutput("stall_aluop", {28'b0, exAluop}, OR_C);
            checkOutput("stall_b", exB, 32'h00008000);
            checkOutput("stall_count", issueCount, 32'd4);
        end

        // Stall and flush together squash the slot.
        applyStimulus(1'b1, 32'h2509FFFC, 32'd99, 32'd1, 1'b1, 1'b1);
        checkOutput("flush_valid", {31'b0, exValid}, 32'd0);
        checkOutput("flush_aluop", {28'b0, exAluop}, NOP_C);
        checkOutput("flush_a", exA, 32'd0);
        checkOutput("flush_count", issueCount, 32'd4);

        // SRAV is unsupported.
        applyStimulus(1'b1, 32'h01095007, 32'd3, 32'd8, 1'b0, 1'b0);
        checkOutput("srav_illegal", {31'b0, exIllegal}, 32'd1);
        checkOutput("srav_aluop", {28'b0, exAluop}, NOP_C);
        checkOutput("srav_regwrite", {31'b0, exRegwrite}, 32'd0);
        checkOutput("srav_count", issueCount, 32'd5);

        // Canonical nop: valid but no writeback.
        applyStimulus(1'b1, 32'h00000000, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("nop_valid", {31'b0, exValid}, 32'd1);
        checkOutput("nop_regwrite", {31'b0, exRegwrite}, 32'd0);
        checkOutput("nop_illegal", {31'b0, exIllegal}, 32'd0);

        // lw $t0,-8($t1)
        applyStimulus(1'b1, 32'h8D28FFF8, 32'h1000, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_aluop", {28'b0, exAluop}, ADD_C);
        checkOutput("lw_b", exB, 32'hFFFFFFF8);
        checkOutput("lw_memrd", {31'b0, exMemRd}, 32'd1);
        checkOutput("lw_regwrite", {31'b0, exRegwrite}, 32'd1);

        // sw $t0,4($t1)
        applyStimulus(1'b1, 32'hAD280004, 32'h1000, 32'hCAFEF00D, 1'b0, 1'b0);
        checkOutput("sw_memwr", {31'b0, exMemWr}, 32'd1);
        checkOutput("sw_regwrite", {31'b0, exRegwrite}, 32'd0);
        checkOutput("sw_rtdata", exRtData, 32'hCAFEF00D);
        checkOutput("sw_b", exB, 32'd4);

        // beq $t0,$t1,...
        applyStimulus(1'b1, 32'h11090010, 32'd7, 32'd9, 1'b0, 1'b0);
        checkOutput("beq_aluop", {28'b0, exAluop}, SUB_C);
        checkOutput("beq_b", exB, 32'd9);
        checkOutput("beq_regwrite", {31'b0, exRegwrite}, 32'd0);
        checkOutput("beq_count", issueCount, 32'd9);

        // Invalid ID slot loads a bubble and does not count.
        applyStimulus(1'b0, 32'h2509FFFC, 32'd1, 32'd1, 1'b0, 1'b0);
        checkOutput("inv_valid", {31'b0, exValid}, 32'd0);
        checkOutput("inv_count", issueCount, 32'd9);

        // Reset during a stall clears the held instruction.
        applyStimulus(1'b1, 32'h2509FFFC, 32'd10, 32'd0, 1'b0, 1'b0);
        checkOutput("pre_rst_count", issueCount, 32'd10);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h2509FFFC, 32'd10, 32'd0, 1'b1, 1'b0);
        checkOutput("rst_stall_valid", {31'b0, exValid}, 32'd0);
        checkOutput("rst_stall_count", issueCount, 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
